// File: rtl/frame_config_loader.sv
// Serial configuration-frame write controller: takes one bitstream bit per
// valid/ready handshake and writes it to the next frame address with setup/strobe/hold.
module frame_config_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WORDS  = 16
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_e;

  // One extra counter bit so the terminal compare cannot wrap at NUM_WORDS = 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        idx_d = '0;
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Address and data only ever change here, which gives setup and hold for free.
        if (cfg_valid && ready_q) begin
          addr_d  = idx_q[ADDR_WIDTH-1:0];
          data_d  = cfg_bit;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they are registered alongside it.
  always_comb begin
    ready_d  = (state_d == S_FETCH);
    enable_d = (state_d == S_STROBE);
    busy_d   = (state_d == S_FETCH) || (state_d == S_SETUP) ||
               (state_d == S_STROBE) || (state_d == S_HOLD);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready = ready_q;
  assign enable    = enable_q;
  assign address   = addr_q;
  assign data_in   = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed/random bench for frame_config_loader: the k-th write of a load must carry
// address k and the k-th bit offered, with the documented latency and reset behaviour.
module tb_frame_config_loader;
  localparam int AW = 4;
  localparam int NW = 16;

  logic          prog_clk  = 1'b0;
  logic          pReset    = 1'b1;
  logic          start     = 1'b0;
  logic          cfg_bit   = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, enable, data_in, busy, done;
  logic [0:AW-1] address;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic          tx_bits[$];
  logic          exp_bits[$];
  logic [AW-1:0] wr_addr[$];
  logic          wr_data[$];

  int   gap_pct = 0;
  int   first_ready_cyc = -1;
  int   done_cyc = -1;
  int   done_wr = 0;
  logic done_busy = 1'b0;
  bit   stall_armed = 0;
  int   stall_idx = 0;
  int   stall_left = 0;
  bit   ign_armed = 0;
  int   ign_idx = 0;
  bit   rst_armed = 0;
  int   rst_idx = 0;
  bit   aborted = 0;

  logic          p1_en, p2_en, p1_d, p2_d;
  logic [AW-1:0] p1_a, p2_a;
  int            h_n = 0;

  frame_config_loader #(.ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .enable    (enable),
    .address   (address),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    check({tag, "_enable"},    32'(enable),    0);
    check({tag, "_address"},   32'(address),   0);
    check({tag, "_data_in"},   32'(data_in),   0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_done"},      32'(done),      0);
  endtask

  // One clock: apply the edge, sample 1 time unit later, then drive the next inputs.
  task automatic step();
    logic hs;
    logic stall_now;
    hs = cfg_ready & cfg_valid;
    @(posedge prog_clk);
    #1;
    cyc++;
    if (hs && tx_bits.size() > 0) void'(tx_bits.pop_front());
    if (cfg_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
    if (done && done_cyc < 0) begin
      done_cyc  = cyc;
      done_wr   = wr_addr.size();
      done_busy = busy;
    end

    // Address/data must be identical the cycle before, during and after a strobe.
    if (h_n >= 2 && p1_en) begin
      check("setup_hold_addr", 32'({p2_a, address}), 32'({p1_a, p1_a}));
      check("setup_hold_data", 32'({p2_d, data_in}), 32'({p1_d, p1_d}));
      check("strobe_width", 32'(enable), 0);
    end
    if (enable) begin
      wr_addr.push_back(address);
      wr_data.push_back(data_in);
    end
    p2_en = p1_en; p2_a = p1_a; p2_d = p1_d;
    p1_en = enable; p1_a = address; p1_d = data_in;
    h_n++;

    stall_now = 1'b0;
    if (stall_armed && cfg_ready && wr_addr.size() == stall_idx) begin
      stall_armed = 0;
      stall_left  = 7;
    end
    if (stall_left > 0) begin
      stall_now = 1'b1;
      stall_left--;
      check("stall_ready",  32'(cfg_ready), 1);
      check("stall_enable", 32'(enable),    0);
      check("stall_addr",   32'(address),   32'(stall_idx - 1));
    end

    start = 1'b0;
    if (ign_armed && enable && wr_addr.size() == ign_idx + 1) begin
      ign_armed = 0;
      start     = 1'b1;
    end

    if (rst_armed && enable && wr_addr.size() == rst_idx + 1) begin
      rst_armed = 0;
      #2 pReset = 1'b1;
      #1;
      check_zero("rst_async");
      aborted = 1;
      h_n     = 0;
      tx_bits.delete();
    end

    // Source: an offered bit stays on the bus until it is actually taken.
    if (aborted || stall_now) begin
      cfg_valid = 1'b0;
    end else if (!cfg_valid || hs) begin
      if (tx_bits.size() > 0 && $urandom_range(99) >= gap_pct) begin
        cfg_valid = 1'b1;
        cfg_bit   = tx_bits[0];
      end else begin
        cfg_valid = 1'b0;
      end
    end
  endtask

  task automatic begin_load(input int gap, input bit fixed_head);
    logic b;
    wr_addr.delete(); wr_data.delete(); exp_bits.delete(); tx_bits.delete();
    for (int k = 0; k < NW; k++) begin
      if (fixed_head && k < 4) b = (k != 1);
      else b = 1'($urandom_range(1));
      exp_bits.push_back(b);
      tx_bits.push_back(b);
    end
    first_ready_cyc = -1;
    done_cyc        = -1;
    aborted         = 0;
    gap_pct         = gap;
    start           = 1'b1;
    step();
  endtask

  task automatic wait_done();
    for (int t = 0; t < 3000 && done_cyc < 0 && !aborted; t++) step();
  endtask

  task automatic verify_writes(input string tag);
    check({tag, "_count"}, 32'(wr_addr.size()), NW);
    for (int k = 0; k < wr_addr.size() && k < NW; k++) begin
      check({tag, "_addr"}, 32'(wr_addr[k]), 32'(k % (1 << AW)));
      check({tag, "_data"}, 32'(wr_data[k]), 32'(exp_bits[k]));
    end
  endtask

  initial begin
    // Reset state, then quiet idle with no start.
    repeat (3) @(posedge prog_clk);
    #1;
    check_zero("reset");
    @(negedge prog_clk) pReset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_quiet", 32'({cfg_ready, enable, address, data_in, busy, done}), 0);
    end

    // Full load with continuous valid: 64 cycles from first ready to done.
    begin_load(0, 1'b1);
    check("A_start_ready", 32'(cfg_ready), 1);
    check("A_start_busy",  32'(busy), 1);
    wait_done();
    check("A_done_seen", 32'(done_cyc >= 0), 1);
    check("A_latency", 32'(done_cyc - first_ready_cyc), 64);
    check("A_done_busy", 32'(done_busy), 0);
    check("A_done_writes", 32'(done_wr), NW);
    verify_writes("A");
    repeat (3) step();
    check("A_hold_done", 32'(done), 1);
    check("A_hold_busy", 32'(busy), 0);
    check("A_hold_ready", 32'(cfg_ready), 0);
    check("A_hold_addr", 32'(address), NW - 1);
    check("A_hold_data", 32'(data_in), 32'(exp_bits[NW-1]));

    // Restart from DONE with a 7-cycle stall at idx 5 and an ignored start at idx 3.
    stall_armed = 1; stall_idx = 5;
    ign_armed   = 1; ign_idx   = 3;
    begin_load(0, 1'b0);
    check("B_done_clear", 32'(done), 0);
    check("B_start_ready", 32'(cfg_ready), 1);
    wait_done();
    check("B_done_seen", 32'(done_cyc >= 0), 1);
    check("B_latency", 32'(done_cyc - first_ready_cyc), 71);
    check("B_ign_used", 32'(ign_armed), 0);
    verify_writes("B");

    // Reset during the strobe of idx 9, then a clean reload from address 0.
    rst_armed = 1; rst_idx = 9;
    begin_load(0, 1'b0);
    wait_done();
    check("C_reset_hit", 32'(aborted), 1);
    check("C_partial_writes", 32'(wr_addr.size()), 10);
    repeat (2) @(negedge prog_clk);
    pReset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("C_idle_after_rst", 32'({cfg_ready, enable, address, data_in, busy, done}), 0);
    end
    begin_load(40, 1'b0);
    wait_done();
    check("D_done_seen", 32'(done_cyc >= 0), 1);
    check("D_done_writes", 32'(done_wr), NW);
    check("D_done_busy", 32'(done_busy), 0);
    verify_writes("D");

    // Heavier random gaps.
    begin_load(65, 1'b0);
    wait_done();
    check("E_done_seen", 32'(done_cyc >= 0), 1);
    check("E_done_writes", 32'(done_wr), NW);
    check("E_min_latency", 32'(done_cyc - first_ready_cyc >= 64), 1);
    verify_writes("E");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_config_loader.md
# frame_config_loader

Configuration-frame write controller for the I/O grid tiles. It sits directly upstream of an I/O grid tile and drives the tile's frame-memory write port (`enable`, `address`, `data_in`). It accepts a serial configuration bitstream over a valid/ready handshake and writes each bit to the next frame address in a setup/strobe/hold sequence. It reports busy/done status to the top-level programming controller.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: width of the frame address.
- `NUM_WORDS`, default 16: number of frame bits to load per `start`. Legal range is 1..2^ADDR_WIDTH.

Ports:
- `prog_clk`, input, 1: programming clock. All logic is on the rising edge.
- `pReset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: single-cycle request to begin a load. Ignored unless the FSM is in IDLE or DONE.
- `cfg_bit`, input, 1: bitstream data bit.
- `cfg_valid`, input, 1: `cfg_bit` is valid.
- `cfg_ready`, output, 1: loader accepts a bit this cycle.
- `enable`, output, 1: frame write strobe to the tile.
- `address`, output, [0:ADDR_WIDTH-1]: frame address, packed MSB-first. `address[0]` is index bit ADDR_WIDTH-1. For the default width, `address[1:3]` are the tile-select bits and `address[0]` is the bit-in-tile select.
- `data_in`, output, 1: frame write data.
- `busy`, output, 1: a load is in progress.
- `done`, output, 1: the last load completed. Held until the next accepted `start` or reset.

## Operation
- FSM states: IDLE, FETCH, SETUP, STROBE, HOLD, DONE.
- IDLE / DONE:
  - `start`=1 goes to FETCH.
  - Word counter `idx` is cleared to 0.
  - `done` is cleared on leaving DONE.
- FETCH:
  - `cfg_ready`=1.
  - On `cfg_valid`&`cfg_ready`: capture `cfg_bit` into `data_in`, load `address`=`idx`, go to SETUP.
  - Without `cfg_valid`, stay in FETCH indefinitely. There is no timeout.
- SETUP: `enable`=0; `address`/`data_in` are stable. Go to STROBE.
- STROBE: `enable`=1 for exactly one cycle. Go to HOLD.
- HOLD:
  - `enable`=0; `address`/`data_in` are still held.
  - If `idx`==NUM_WORDS-1, go to DONE. Otherwise `idx`+=1 and go to FETCH.
- `address` and `data_in` change only on the FETCH→SETUP transition. They hold their value in all other states, including DONE.
- `idx` is ADDR_WIDTH+1 bits wide internally, so the terminal compare never wraps. `address` is `idx[ADDR_WIDTH-1:0]`.
- `busy`=1 in FETCH, SETUP, STROBE and HOLD; 0 in IDLE and DONE.
- `cfg_ready` is 0 in every state except FETCH. A `cfg_valid` outside FETCH is not consumed; the source holds it.
- `start` while busy is ignored and has no side effect.

## Timing
- Reset values: state=IDLE, `cfg_ready`=0, `enable`=0, `address`=0, `data_in`=0, `busy`=0, `done`=0, `idx`=0.
- All outputs are registered. `cfg_ready` is a function of the registered state only; there is no combinational path from inputs.
- `start` accepted at edge N: FETCH and `busy`=1 are visible after edge N, i.e. `cfg_ready`=1 in cycle N+1.
- Handshake at edge M: SETUP is visible in cycle M+1, `enable`=1 in cycle M+2, and HOLD in cycle M+3.
  - The next `cfg_ready` is in cycle M+4.
  - Best-case throughput is 1 bit per 4 cycles. A full 16-word load takes 64 cycles after the first `cfg_ready`.
- Setup and hold around the strobe are guaranteed: `address`/`data_in` are stable ≥1 cycle before and ≥1 cycle after the `enable`-high cycle.
- DONE:
  - `done`=1 is visible the cycle after the last HOLD; `busy` falls in that same cycle.
  - `start` in DONE clears `done` at the same edge that enters FETCH.
- Reset mid-operation:
  - `pReset` asserted asynchronously forces all reset values immediately, including `enable`=0 mid-strobe.
  - No partial frame write completes after reset.
  - After deassertion, the FSM waits in IDLE for `start`.
- NUM_WORDS=1: one FETCH/SETUP/STROBE/HOLD sequence, then DONE.

## Test plan
- Reset check: assert `pReset` asynchronously between clock edges → all outputs are 0 within the same cycle; after release with no `start`, outputs stay 0 for 10 cycles.
- Full load: `start`, then continuous `cfg_valid`=1 with bits 1,0,1,1,… (16 bits) → exactly 16 `enable` pulses.
  - Addresses 0..15 in order; `data_in` matches each bit at its strobe.
  - `done`=1 64 cycles after the first `cfg_ready`; `busy`=0 from that cycle.
- Back-pressure / stall: `cfg_valid` low for 7 cycles in FETCH at idx=5 → `cfg_ready` stays 1, no `enable`, and `address` holds 4; the load resumes correctly when valid returns.
- Setup/hold checker: on every `enable`=1 cycle, `address` and `data_in` equal their values from the previous and next cycles. A `cfg_valid` outside FETCH is not consumed (sequence compare against a scoreboard).
- Ignored start: pulse `start` at idx=3 during STROBE → no restart; `idx` continues, and the address sequence is unchanged.
- Reset mid-strobe, then restart: assert `pReset` in the STROBE cycle at idx=9 → `enable` drops immediately. A new `start` reloads from address 0, and `done` is set only after 16 new writes.
